latrs_bank_ctrl: RTL and testbench

LATRS_BANK_CTRL -- requirements
Module: latrs_bank_ctrl

---
 rtl/latrs_bank_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_latrs_bank_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latrs_bank_ctrl.sv
// -----------------------------------------------------------------------------
// latrs_bank_ctrl
//
// Sequencer for a bank of NBANK transparent latch words that share one D bus.
// Each accepted request drives one word through a setup / strobe / hold
// sequence:
//   - WRITE  : the word's enable is pulsed.
//   - CLEAR  : the word's active-low clear is pulsed.
//   - PRESET : the word's active-low preset is pulsed.
// A request with an illegal opcode, or with a bank index that does not exist,
// is rejected with a one-cycle error pulse.
//
// Every output comes straight from a flop. The next value of each output is
// worked out from the next FSM state, so the outputs change in the same cycle
// that the state does.
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst        synchronous active-high reset
//   i_req_valid  a request is present
//   o_req_ready  high only in IDLE; a request is accepted on valid & ready
//   i_req_op     00 WRITE, 01 CLEAR, 10 PRESET, 11 illegal
//   i_req_bank   index of the target latch word
//   i_req_data   write data (used by WRITE only)
//   o_lat_d      shared D bus to all latch words
//   o_lat_e      per-word enable, active-high
//   o_lat_rn     per-word clear, active-low
//   o_lat_setn   per-word preset, active-low
//   o_busy       high in every state except IDLE
//   o_done       one-cycle completion pulse (the DONE state)
//   o_err        one-cycle rejection pulse
// -----------------------------------------------------------------------------
module latrs_bank_ctrl #(
    parameter int WIDTH   = 8,
    parameter int NBANK   = 4,   // 1..16
    parameter int T_SETUP = 1,   // 1..15
    parameter int T_PULSE = 2,   // 1..15
    parameter int T_HOLD  = 1    // 1..15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_req_op,
    input  logic [3:0]       i_req_bank,
    input  logic [WIDTH-1:0] i_req_data,
    output logic [WIDTH-1:0] o_lat_d,
    output logic [NBANK-1:0] o_lat_e,
    output logic [NBANK-1:0] o_lat_rn,
    output logic [NBANK-1:0] o_lat_setn,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_CLEAR   = 2'b01,
        OP_PRESET  = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    // Each phase counter is loaded with (length - 1) when its phase is
    // entered, and counts down to zero.
    localparam logic [3:0] C_SETUP = 4'(T_SETUP - 1);
    localparam logic [3:0] C_PULSE = 4'(T_PULSE - 1);
    localparam logic [3:0] C_HOLD  = 4'(T_HOLD - 1);

    state_e           r_state;
    logic [3:0]       r_cnt;
    op_e              r_op;
    logic [3:0]       r_bank;

    logic             r_req_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_lat_d;
    logic [NBANK-1:0] r_lat_e;
    logic [NBANK-1:0] r_lat_rn;
    logic [NBANK-1:0] r_lat_setn;

    state_e           w_state_next;
    logic [3:0]       w_cnt_next;
    logic             w_accept;
    logic             w_illegal;
    logic             w_start;
    logic [NBANK-1:0] w_sel;

    assign w_accept  = i_req_valid && r_req_ready;
    assign w_illegal = (i_req_op == OP_ILLEGAL) || (int'(i_req_bank) >= NBANK);
    assign w_start   = w_accept && !w_illegal;

    // One-hot select of the captured bank. A bank index outside the array is
    // rejected before it is captured, so exactly one bit is ever set.
    always_comb begin
        for (int i = 0; i < NBANK; i++) begin
            w_sel[i] = (r_bank == 4'(i));
        end
    end

    // Next-state logic. The phase counter is reloaded on every transition.
    always_comb begin
        // NOTE: give every variable a default before the case statement, so
        // that no path leaves it unassigned and no latch is inferred.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_SETUP;
                    w_cnt_next   = C_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_PULSE;
                    w_cnt_next   = C_PULSE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_PULSE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = C_HOLD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge, whatever the order of the
        // statements.
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_op        <= OP_WRITE;
            r_bank      <= 4'd0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_lat_d     <= '0;
            r_lat_e     <= '0;
            r_lat_rn    <= '1;
            r_lat_setn  <= '1;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_req_ready <= (w_state_next == S_IDLE);
            r_busy      <= (w_state_next != S_IDLE);
            r_done      <= (w_state_next == S_DONE);
            r_err       <= w_accept && w_illegal;

            if (w_start) begin
                r_op   <= op_e'(i_req_op);
                r_bank <= i_req_bank;
                // The D bus takes the write data in the first SETUP cycle and
                // keeps it until the next WRITE.
                if (i_req_op == OP_WRITE) begin
                    r_lat_d <= i_req_data;
                end
            end

            // A strobe is driven only while the next state is PULSE. In every
            // other state all three strobe buses sit at their idle levels.
            // r_op and r_bank are stable here: SETUP is always at least one
            // cycle, so they were captured before PULSE is entered.
            r_lat_e    <= '0;
            r_lat_rn   <= '1;
            r_lat_setn <= '1;
            if (w_state_next == S_PULSE) begin
                unique case (r_op)
                    OP_WRITE:  r_lat_e    <= w_sel;
                    OP_CLEAR:  r_lat_rn   <= ~w_sel;
                    OP_PRESET: r_lat_setn <= ~w_sel;
                    default:   ;
                endcase
            end
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_lat_d     = r_lat_d;
    assign o_lat_e     = r_lat_e;
    assign o_lat_rn    = r_lat_rn;
    assign o_lat_setn  = r_lat_setn;

endmodule

// File: tb/tb_latrs_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_latrs_bank_ctrl
//
// Directed bench for latrs_bank_ctrl with its default parameters
// (WIDTH=8, NBANK=4, T_SETUP=1, T_PULSE=2, T_HOLD=1). All expected values are
// written out by hand, cycle by cycle. The cycle after the accepting edge is
// called cycle 1.
//
// A separate checker tests the strobe exclusivity rules on every falling
// edge.
// -----------------------------------------------------------------------------
module tb_latrs_bank_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_bank;
    logic [7:0] req_data;
    logic [7:0] lat_d;
    logic [3:0] lat_e;
    logic [3:0] lat_rn;
    logic [3:0] lat_setn;
    logic       busy;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_PRE = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    latrs_bank_ctrl #(
        .WIDTH   (8),
        .NBANK   (4),
        .T_SETUP (1),
        .T_PULSE (2),
        .T_HOLD  (1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_bank  (req_bank),
        .i_req_data  (req_data),
        .o_lat_d     (lat_d),
        .o_lat_e     (lat_e),
        .o_lat_rn    (lat_rn),
        .o_lat_setn  (lat_setn),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare the full visible state of the controller in one call.
    task automatic chk_all(input string tag,
                           input logic [3:0] e, input logic [3:0] rn,
                           input logic [3:0] setn, input logic [7:0] d,
                           input logic ready, input logic bsy,
                           input logic dn, input logic er);
        chk({tag, ".lat_e"},    32'(lat_e),     32'(e));
        chk({tag, ".lat_rn"},   32'(lat_rn),    32'(rn));
        chk({tag, ".lat_setn"}, 32'(lat_setn),  32'(setn));
        chk({tag, ".lat_d"},    32'(lat_d),     32'(d));
        chk({tag, ".ready"},    32'(req_ready), 32'(ready));
        chk({tag, ".busy"},     32'(busy),      32'(bsy));
        chk({tag, ".done"},     32'(done),      32'(dn));
        chk({tag, ".err"},      32'(err),       32'(er));
    endtask

    // On every cycle, check that at most one bank is strobed, that clear and
    // preset are never low together, and that enable is never high while
    // either is low.
    logic [3:0] w_strobe;
    assign w_strobe = lat_e | ~lat_rn | ~lat_setn;

    always @(negedge clk) begin
        if (!rst) begin
            n_tests++;
            assert ($onehot0(w_strobe) && ((~lat_rn & ~lat_setn) == 4'h0) &&
                    ((lat_e & (~lat_rn | ~lat_setn)) == 4'h0)) else begin
                n_fail++;
                $error("FAIL strobe_excl: observed e=%b rn=%b setn=%b required one strobe at most, no overlap",
                       lat_e, lat_rn, lat_setn);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_WR;
        req_bank  = 4'd0;
        req_data  = 8'h00;
        tick();
        tick();
        chk_all("reset", 4'h0, 4'hF, 4'hF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("idle", 4'h0, 4'hF, 4'hF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // WRITE bank 2 with data 0xA5.
        req_valid = 1'b1; req_op = OP_WR; req_bank = 4'd2; req_data = 8'hA5;
        tick();
        req_valid = 1'b0; req_data = 8'h00;
        chk_all("wr.c1", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("wr.c2", 4'h4, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("wr.c3", 4'h4, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("wr.c4", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("wr.c5", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("wr.c6", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

        // CLEAR bank 0, then PRESET bank 3 held on the request lines so that
        // it is taken in the first IDLE cycle.
        req_valid = 1'b1; req_op = OP_CLR; req_bank = 4'd0; req_data = 8'hFF;
        tick();
        req_op = OP_PRE; req_bank = 4'd3; req_data = 8'h33;
        chk_all("clr.c1", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("clr.c2", 4'h0, 4'hE, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("clr.c3", 4'h0, 4'hE, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("clr.c4", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("clr.c5", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("clr.c6", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        chk_all("pre.c1", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("pre.c2", 4'h0, 4'hF, 4'h7, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("pre.c3", 4'h0, 4'hF, 4'h7, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("pre.c4", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("pre.c5", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("pre.c6", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Rejected requests: illegal opcode, bank 4 (first index past the
        // end), bank 5 with WRITE data that must not reach the D bus.
        req_valid = 1'b1; req_op = OP_BAD; req_bank = 4'd0; req_data = 8'h11;
        tick();
        chk_all("err.op", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        req_op = OP_CLR; req_bank = 4'd4;
        tick();
        chk_all("err.b4", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        req_op = OP_WR; req_bank = 4'd5; req_data = 8'h11;
        tick();
        req_valid = 1'b0;
        chk_all("err.b5", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("err.end", 4'h0, 4'hF, 4'hF, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the second PULSE cycle of a WRITE to bank 1.
        req_valid = 1'b1; req_op = OP_WR; req_bank = 4'd1; req_data = 8'h3C;
        tick();
        req_valid = 1'b0;
        chk_all("rst.c1", 4'h0, 4'hF, 4'hF, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("rst.c2", 4'h2, 4'hF, 4'hF, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        chk_all("rst.c3", 4'h2, 4'hF, 4'hF, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        chk_all("rst.c4", 4'h0, 4'hF, 4'hF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("rst.c5", 4'h0, 4'hF, 4'hF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset takes priority over a request at the same edge.
        rst = 1'b1;
        req_valid = 1'b1; req_op = OP_WR; req_bank = 4'd0; req_data = 8'h77;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        chk_all("rstreq.c1", 4'h0, 4'hF, 4'hF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("rstreq.c2", 4'h0, 4'hF, 4'hF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Valid held high with data changing while busy. Only the data at
        // each acceptance may reach the D bus; the second write is taken
        // back-to-back in the first IDLE cycle.
        req_valid = 1'b1; req_op = OP_WR; req_bank = 4'd3; req_data = 8'h5A;
        tick();
        req_data = 8'hC3;
        chk_all("hold.c1", 4'h0, 4'hF, 4'hF, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        req_data = 8'h99;
        chk_all("hold.c2", 4'h8, 4'hF, 4'hF, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        req_data = 8'hE7;
        chk_all("hold.c3", 4'h8, 4'hF, 4'hF, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("hold.c4", 4'h0, 4'hF, 4'hF, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        req_data = 8'h42;
        chk_all("hold.c5", 4'h0, 4'hF, 4'hF, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("hold.c6", 4'h0, 4'hF, 4'hF, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        chk_all("b2b.c1", 4'h0, 4'hF, 4'hF, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("b2b.c2", 4'h8, 4'hF, 4'hF, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk_all("b2b.c5", 4'h0, 4'hF, 4'hF, 8'h42, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("b2b.c6", 4'h0, 4'hF, 4'hF, 8'h42, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
